mem_bus_access: RTL and testbench
=================================

# mem_bus_access

Memory-stage load/store unit sitting directly downstream of the EX/MEM pipeline register and upstream of MEM/WB. It decodes the load/store ALU op and runs a request/acknowledge transaction on the data bus. It holds the pipeline with `stall_request` until the bus answers, then formats load data (big-endian, sign/zero extension) onto the write-back path. Non-memory ops pass through combinationally.

## Interface
Parameters:
- `BUS_TIMEOUT`, 16, BUSY cycles without `bus_ack` before the access is abandoned; legal range 2..255.

Ports:
- `clock`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `flush_input`  in  1  exception flush; aborts any access in flight
- `aluop_input`  in  8  ALU op from EX/MEM
- `memory_address_input`  in  32  effective address
- `reg2_input`  in  32  store data source
- `write_reg_address_input` / `write_reg_enable_input` / `write_reg_data_input`  in  5/1/32  write-back request from EX/MEM
- `bus_request`  out  1  transaction valid, registered
- `bus_write_enable`  out  1  1 = store, registered
- `bus_address`  out  32  word address `{addr[31:2],2'b00}`, registered
- `bus_select`  out  4  byte lanes, bit 3 = bits 31:24, registered
- `bus_write_data`  out  32  store data, registered
- `bus_read_data`  in  32  load data, sampled when `bus_ack`=1
- `bus_ack`  in  1  transaction complete
- `stall_request`  out  1  to ctrl; holds stages 0..4
- `write_reg_address_output` / `write_reg_enable_output` / `write_reg_data_output`  out  5/1/32  to MEM/WB
- `load_address_error` / `store_address_error`  out  1/1  misaligned access flags
- `bus_error`  out  1  timeout flag, one cycle

## Operation
- Memory ops:
  - LB `8'b11100000`, LBU `11100100`, LH `11100001`, LHU `11100101`, LW `11100011`.
  - SB `11101000`, SH `11101001`, SW `11101011`.
  - Every other code is a non-memory op.
- Non-memory op: the three write-back outputs equal their inputs, `stall_request`=0, and the FSM stays in IDLE.
- Alignment rule: a halfword op with `addr[0]`=1, or a word op with `addr[1:0]`≠0, is misaligned.
  - The matching error flag goes high combinationally.
  - No bus access starts, `stall_request`=0, `write_reg_enable_output`=0.
- Store lanes (big-endian):
  - SB: sel `1000>>addr[1:0]`, data `{4{reg2[7:0]}}`.
  - SH: sel `1100` if `addr[1]`=0, else `0011`; data `{2{reg2[15:0]}}`.
  - SW: sel `1111`, data `reg2`.
- Load lanes: the same select patterns are used. The selected byte or halfword is sign-extended (LB/LH) or zero-extended (LBU/LHU).
- FSM states:
  - IDLE: on an aligned memory op with no flush, latch the bus outputs, assert `stall_request`, go to BUSY.
  - BUSY: `bus_request`=1, `stall_request`=1, timeout counter increments.
    - `bus_ack`=1: capture the formatted load into `load_data_q`, drop `bus_request`, go to DONE.
    - Counter reaches `BUS_TIMEOUT-1` with no ack: drop `bus_request`, set the error latch, go to DONE.
  - DONE: `stall_request`=0.
    - Load: `write_reg_data_output` = `load_data_q`, enable = input enable.
    - Store: enable = input enable.
    - Timed-out access: `bus_error`=1 and `write_reg_enable_output`=0.
    - Always go to IDLE next cycle. EX/MEM advances on this edge.
- In IDLE and BUSY with a memory op present, `write_reg_enable_output`=0.
- `flush_input`=1 in any state:
  - Next state is IDLE; `bus_request`/`bus_write_enable` are 0 next cycle; the counter and error latch clear.
  - Outputs this cycle: `stall_request`=0, `write_reg_enable_output`=0.
- `bus_ack` is ignored outside BUSY. The slave tolerates `bus_request` dropping before ack.

## Timing
- Reset (synchronous, dominates flush):
  - Registers: state=IDLE, counter 0, `load_data_q` 0; `bus_request`, `bus_write_enable`, `bus_address`, `bus_select`, `bus_write_data` all 0.
  - Combinational outputs forced while `reset`=1: `stall_request` 0; write-back address, enable and data 0; both address-error flags 0; `bus_error` 0.
- Load or store with zero-wait ack:
  - Op visible at cycle T (IDLE, stall=1).
  - T+1: BUSY, `bus_request`=1, `bus_ack`=1.
  - T+2: DONE, result valid, stall=0.
  - Total: 3 cycles, 2 stall cycles.
- Each wait cycle adds one cycle.
- Timeout: DONE is reached at T+1+`BUS_TIMEOUT`.
- Back-to-back memory ops: the second op enters IDLE at T+3 and starts a new transaction. There are no bubbles beyond the 2 stall cycles per access.
- Reset mid-transaction: `bus_request` is 0 on the next edge; there is no pending state.

## Test plan
- LW addr `0x100`, ack at first BUSY cycle, read `0xDEADBEEF` → stall high for 2 cycles; DONE output data `0xDEADBEEF`, enable=1; `bus_select`=`1111`.
- LB addr `0x103`, read `0x123456F0` → output `0xFFFFFFF0`. Same with LBU → `0x000000F0`. LH addr `0x102`, read `0x00008001` → `0xFFFF8001`.
- SH addr `0x22`, reg2 `0x0000ABCD`, ack after 3 waits → `bus_write_enable`=1, sel `0011`, data `0xABCDABCD`; `bus_request` high 4 cycles; stall high 5 cycles.
- LW addr `0x101` → `load_address_error`=1, `bus_request` never rises, stall=0, enable=0. SW addr `0x102` → `store_address_error`=1.
- LW with no ack, `BUS_TIMEOUT`=16 → `bus_request` high 16 cycles; DONE with `bus_error`=1 for one cycle, enable=0; IDLE next cycle.
- Flush during BUSY, then late `bus_ack` → `bus_request` 0 next cycle, FSM IDLE, the ack is ignored. Assert reset mid-BUSY → all registered outputs 0 next cycle.

Source files
------------

// File: rtl/mem_bus_access.sv
// Memory-stage load/store unit: decodes load/store ops, runs a req/ack
// bus transaction while stalling the pipe, formats big-endian load data.
module mem_bus_access #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush_input,
    input  logic [7:0]  aluop_input,
    input  logic [31:0] memory_address_input,
    input  logic [31:0] reg2_input,
    input  logic [4:0]  write_reg_address_input,
    input  logic        write_reg_enable_input,
    input  logic [31:0] write_reg_data_input,
    output logic        bus_request,
    output logic        bus_write_enable,
    output logic [31:0] bus_address,
    output logic [3:0]  bus_select,
    output logic [31:0] bus_write_data,
    input  logic [31:0] bus_read_data,
    input  logic        bus_ack,
    output logic        stall_request,
    output logic [4:0]  write_reg_address_output,
    output logic        write_reg_enable_output,
    output logic [31:0] write_reg_data_output,
    output logic        load_address_error,
    output logic        store_address_error,
    output logic        bus_error
);

    localparam logic [7:0] OP_LB  = 8'b11100000;
    localparam logic [7:0] OP_LBU = 8'b11100100;
    localparam logic [7:0] OP_LH  = 8'b11100001;
    localparam logic [7:0] OP_LHU = 8'b11100101;
    localparam logic [7:0] OP_LW  = 8'b11100011;
    localparam logic [7:0] OP_SB  = 8'b11101000;
    localparam logic [7:0] OP_SH  = 8'b11101001;
    localparam logic [7:0] OP_SW  = 8'b11101011;

    localparam logic [7:0] TIMEOUT_LAST = 8'(BUS_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [7:0]  timeout_count;
    logic        timeout_q;
    logic [31:0] load_data_q;

    logic        is_load;
    logic        is_store;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        is_unsigned;
    logic        misaligned;
    logic        access_ok;
    logic [1:0]  addr_lo;
    logic [3:0]  lane_select;
    logic [31:0] lane_data;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_format;

    assign addr_lo = memory_address_input[1:0];

    always_comb begin
        is_load     = 1'b0;
        is_store    = 1'b0;
        is_byte     = 1'b0;
        is_half     = 1'b0;
        is_word     = 1'b0;
        is_unsigned = 1'b0;
        case (aluop_input)
            OP_LB:  begin is_load = 1'b1; is_byte = 1'b1; end
            OP_LBU: begin
                is_load = 1'b1; is_byte = 1'b1; is_unsigned = 1'b1;
            end
            OP_LH:  begin is_load = 1'b1; is_half = 1'b1; end
            OP_LHU: begin
                is_load = 1'b1; is_half = 1'b1; is_unsigned = 1'b1;
            end
            OP_LW:  begin is_load = 1'b1; is_word = 1'b1; end
            OP_SB:  begin is_store = 1'b1; is_byte = 1'b1; end
            OP_SH:  begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW:  begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

    assign misaligned = (is_half & addr_lo[0]) | (is_word & (|addr_lo));
    assign access_ok  = (is_load | is_store) & ~misaligned;

    // Big-endian lanes: byte 0 of the word lives in bits 31:24
    always_comb begin
        lane_select = 4'b0000;
        lane_data   = 32'h0;
        unique case (1'b1)
            is_byte: begin
                lane_select = 4'b1000 >> addr_lo;
                lane_data   = {4{reg2_input[7:0]}};
            end
            is_half: begin
                lane_select = addr_lo[1] ? 4'b0011 : 4'b1100;
                lane_data   = {2{reg2_input[15:0]}};
            end
            is_word: begin
                lane_select = 4'b1111;
                lane_data   = reg2_input;
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_lane = bus_read_data[31:24];
        case (addr_lo)
            2'd0: byte_lane = bus_read_data[31:24];
            2'd1: byte_lane = bus_read_data[23:16];
            2'd2: byte_lane = bus_read_data[15:8];
            2'd3: byte_lane = bus_read_data[7:0];
            default: ;
        endcase
        half_lane = addr_lo[1] ? bus_read_data[15:0]
                               : bus_read_data[31:16];
        load_format = bus_read_data;
        if (is_byte)
            load_format = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
        else if (is_half)
            load_format = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
    end

    always_comb begin
        next_state               = state;
        stall_request            = 1'b0;
        write_reg_address_output = write_reg_address_input;
        write_reg_enable_output  = write_reg_enable_input;
        write_reg_data_output    = write_reg_data_input;
        load_address_error       = is_load & misaligned;
        store_address_error      = is_store & misaligned;
        bus_error                = 1'b0;
        if (reset) begin
            next_state               = IDLE;
            write_reg_address_output = 5'd0;
            write_reg_enable_output  = 1'b0;
            write_reg_data_output    = 32'h0;
            load_address_error       = 1'b0;
            store_address_error      = 1'b0;
        end else if (flush_input) begin
            next_state              = IDLE;
            write_reg_enable_output = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_load | is_store)
                        write_reg_enable_output = 1'b0;
                    if (access_ok) begin
                        stall_request = 1'b1;
                        next_state    = BUSY;
                    end
                end
                BUSY: begin
                    stall_request = 1'b1;
                    if (is_load | is_store)
                        write_reg_enable_output = 1'b0;
                    if (bus_ack || timeout_count == TIMEOUT_LAST)
                        next_state = DONE;
                end
                DONE: begin
                    next_state = IDLE;
                    if (timeout_q) begin
                        bus_error               = 1'b1;
                        write_reg_enable_output = 1'b0;
                    end else if (is_load) begin
                        write_reg_data_output = load_data_q;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            timeout_count    <= 8'd0;
            timeout_q        <= 1'b0;
            load_data_q      <= 32'h0;
            bus_request      <= 1'b0;
            bus_write_enable <= 1'b0;
            bus_address      <= 32'h0;
            bus_select       <= 4'b0000;
            bus_write_data   <= 32'h0;
        end else if (flush_input) begin
            state            <= IDLE;
            timeout_count    <= 8'd0;
            timeout_q        <= 1'b0;
            bus_request      <= 1'b0;
            bus_write_enable <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (access_ok) begin
                        bus_request      <= 1'b1;
                        bus_write_enable <= is_store;
                        bus_address      <= {memory_address_input[31:2],
                                             2'b00};
                        bus_select       <= lane_select;
                        bus_write_data   <= lane_data;
                        timeout_count    <= 8'd0;
                        timeout_q        <= 1'b0;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        load_data_q      <= load_format;
                        bus_request      <= 1'b0;
                        bus_write_enable <= 1'b0;
                    end else if (timeout_count == TIMEOUT_LAST) begin
                        bus_request      <= 1'b0;
                        bus_write_enable <= 1'b0;
                        timeout_q        <= 1'b1;
                    end else begin
                        timeout_count <= timeout_count + 8'd1;
                    end
                end
                DONE: begin
                    timeout_count <= 8'd0;
                    timeout_q     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_access.sv
// Scoreboard bench for mem_bus_access: a bus slave model answers
// requests after a chosen wait count; results are checked per scenario.
module tb_mem_bus_access;

    localparam logic [7:0] LB  = 8'b11100000;
    localparam logic [7:0] LBU = 8'b11100100;
    localparam logic [7:0] LH  = 8'b11100001;
    localparam logic [7:0] LHU = 8'b11100101;
    localparam logic [7:0] LW  = 8'b11100011;
    localparam logic [7:0] SB  = 8'b11101000;
    localparam logic [7:0] SH  = 8'b11101001;
    localparam logic [7:0] SW  = 8'b11101011;
    localparam logic [7:0] NOP = 8'h00;

    logic        clock;
    logic        reset;
    logic        flush_input;
    logic [7:0]  aluop_input;
    logic [31:0] memory_address_input;
    logic [31:0] reg2_input;
    logic [4:0]  write_reg_address_input;
    logic        write_reg_enable_input;
    logic [31:0] write_reg_data_input;
    logic        bus_request;
    logic        bus_write_enable;
    logic [31:0] bus_address;
    logic [3:0]  bus_select;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;
    logic        bus_ack;
    logic        stall_request;
    logic [4:0]  write_reg_address_output;
    logic        write_reg_enable_output;
    logic [31:0] write_reg_data_output;
    logic        load_address_error;
    logic        store_address_error;
    logic        bus_error;

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] wd;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [4:0]  wa;
        logic        en;
        logic        err;
        logic        lerr;
        logic        serr;
        logic        bwe;
        int          cycles;
        int          stalls;
        int          reqs;
    } obs_t;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  sel;
        logic        en;
        int          stalls;
    } exp_t;

    obs_t obs_q[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    mem_bus_access #(.BUS_TIMEOUT(16)) dut (
        .clock(clock),
        .reset(reset),
        .flush_input(flush_input),
        .aluop_input(aluop_input),
        .memory_address_input(memory_address_input),
        .reg2_input(reg2_input),
        .write_reg_address_input(write_reg_address_input),
        .write_reg_enable_input(write_reg_enable_input),
        .write_reg_data_input(write_reg_data_input),
        .bus_request(bus_request),
        .bus_write_enable(bus_write_enable),
        .bus_address(bus_address),
        .bus_select(bus_select),
        .bus_write_data(bus_write_data),
        .bus_read_data(bus_read_data),
        .bus_ack(bus_ack),
        .stall_request(stall_request),
        .write_reg_address_output(write_reg_address_output),
        .write_reg_enable_output(write_reg_enable_output),
        .write_reg_data_output(write_reg_data_output),
        .load_address_error(load_address_error),
        .store_address_error(store_address_error),
        .bus_error(bus_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Drives one op (called just after a rising edge) and plays the slave;
    // waits < 0 means the slave never acknowledges.
    task automatic do_access(input logic [7:0] op, input logic [31:0] addr,
                             input logic [31:0] r2, input logic [31:0] rd,
                             input int waits);
        obs_t o;
        int   wcnt;
        bit   fin;
        o    = '0;
        wcnt = 0;
        fin  = 0;
        aluop_input             = op;
        memory_address_input    = addr;
        reg2_input              = r2;
        bus_read_data           = rd;
        write_reg_address_input = 5'd9;
        write_reg_enable_input  = 1'b1;
        write_reg_data_input    = 32'h5A5A_1234;
        while (!fin && o.cycles < 100) begin
            @(negedge clock);
            o.cycles++;
            if (bus_request) begin
                o.reqs++;
                o.sel  = bus_select;
                o.wd   = bus_write_data;
                o.addr = bus_address;
                o.bwe  = bus_write_enable;
            end
            if (stall_request) begin
                o.stalls++;
            end else begin
                fin    = 1;
                o.d    = write_reg_data_output;
                o.en   = write_reg_enable_output;
                o.wa   = write_reg_address_output;
                o.err  = bus_error;
                o.lerr = load_address_error;
                o.serr = store_address_error;
            end
            bus_ack = bus_request && (wcnt == waits);
            if (bus_request) wcnt++;
        end
        if (!fin) begin
            checks++;
            $display("FAIL access_bound op=%h stalled %0d cycles", op,
                     o.cycles);
        end
        obs_q.push_back(o);
        @(posedge clock);
        #1;
        bus_ack                = 1'b0;
        aluop_input            = NOP;
        write_reg_enable_input = 1'b0;
    endtask

    task automatic test_reset;
        reset                   = 1'b1;
        flush_input             = 1'b0;
        bus_ack                 = 1'b0;
        bus_read_data           = 32'hFFFF_FFFF;
        aluop_input             = LW;
        memory_address_input    = 32'h101;
        reg2_input              = 32'h1;
        write_reg_address_input = 5'd3;
        write_reg_enable_input  = 1'b1;
        write_reg_data_input    = 32'hCAFE_F00D;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({stall_request, load_address_error, bus_error} !== 3'b000)
            $display("FAIL reset_flags got %b want 000",
                     {stall_request, load_address_error, bus_error});
        else passes++;
        checks++;
        if ({write_reg_address_output, write_reg_enable_output,
             write_reg_data_output} !== 38'h0)
            $display("FAIL reset_wb got %h/%b/%h want 0",
                     write_reg_address_output, write_reg_enable_output,
                     write_reg_data_output);
        else passes++;
        checks++;
        if ({bus_request, bus_write_enable, bus_address, bus_select,
             bus_write_data} !== 70'h0)
            $display("FAIL reset_bus got req=%b addr=%h want 0",
                     bus_request, bus_address);
        else passes++;
        @(posedge clock);
        #1;
        reset                  = 1'b0;
        aluop_input            = NOP;
        write_reg_enable_input = 1'b0;
    endtask

    task automatic test_load_word;
        obs_t o;
        exp_t e;
        exp_q.push_back('{d: 32'hDEADBEEF, sel: 4'b1111, en: 1'b1,
                          stalls: 2});
        do_access(LW, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (o.d !== e.d || o.en !== e.en)
            $display("FAIL lw_data got %h en=%b want %h en=%b",
                     o.d, o.en, e.d, e.en);
        else passes++;
        checks++;
        if (o.stalls !== e.stalls || o.cycles !== 3 || o.reqs !== 1)
            $display("FAIL lw_timing got stall=%0d cyc=%0d req=%0d want 2/3/1",
                     o.stalls, o.cycles, o.reqs);
        else passes++;
        checks++;
        if (o.sel !== e.sel || o.bwe !== 1'b0 || o.addr !== 32'h100)
            $display("FAIL lw_bus got sel=%b we=%b addr=%h want 1111/0/100",
                     o.sel, o.bwe, o.addr);
        else passes++;
    endtask

    task automatic test_load_lanes;
        logic [7:0]  ops [6];
        logic [31:0] adr [6];
        logic [31:0] rdv [6];
        ops = '{LB, LBU, LH, LB, LHU, LBU};
        adr = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h100, 32'h101};
        rdv = '{32'h123456F0, 32'h123456F0, 32'h00008001,
                32'h80AA_BBCC, 32'h8001_7777, 32'h11C3_2233};
        exp_q.push_back('{d: 32'hFFFFFFF0, sel: 4'b0001, en: 1, stalls: 2});
        exp_q.push_back('{d: 32'h000000F0, sel: 4'b0001, en: 1, stalls: 2});
        exp_q.push_back('{d: 32'hFFFF8001, sel: 4'b0011, en: 1, stalls: 2});
        exp_q.push_back('{d: 32'hFFFFFF80, sel: 4'b1000, en: 1, stalls: 2});
        exp_q.push_back('{d: 32'h00008001, sel: 4'b1100, en: 1, stalls: 2});
        exp_q.push_back('{d: 32'h000000C3, sel: 4'b0100, en: 1, stalls: 2});
        for (int i = 0; i < 6; i++)
            do_access(ops[i], adr[i], 32'h0, rdv[i], i % 2);
        for (int i = 0; i < 6; i++) begin
            obs_t o;
            exp_t e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.d !== e.d || o.sel !== e.sel || o.en !== e.en)
                $display("FAIL load_lane%0d got %h sel=%b en=%b want %h sel=%b",
                         i, o.d, o.sel, o.en, e.d, e.sel);
            else passes++;
        end
    endtask

    task automatic test_store;
        obs_t o;
        exp_t e;
        exp_q.push_back('{d: 32'h5A5A1234, sel: 4'b0011, en: 1, stalls: 5});
        exp_q.push_back('{d: 32'h5A5A1234, sel: 4'b0100, en: 1, stalls: 3});
        do_access(SH, 32'h22, 32'h0000ABCD, 32'h0, 3);
        do_access(SB, 32'h41, 32'h0000_0077, 32'h0, 1);
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (o.bwe !== 1'b1 || o.sel !== e.sel || o.wd !== 32'hABCDABCD ||
            o.addr !== 32'h20)
            $display("FAIL sh_bus got we=%b sel=%b wd=%h addr=%h",
                     o.bwe, o.sel, o.wd, o.addr);
        else passes++;
        checks++;
        if (o.reqs !== 4 || o.stalls !== e.stalls || o.en !== e.en)
            $display("FAIL sh_timing got req=%0d stall=%0d en=%b want 4/5/1",
                     o.reqs, o.stalls, o.en);
        else passes++;
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (o.sel !== e.sel || o.wd !== 32'h77777777 ||
            o.stalls !== e.stalls || o.d !== e.d)
            $display("FAIL sb got sel=%b wd=%h stall=%0d d=%h",
                     o.sel, o.wd, o.stalls, o.d);
        else passes++;
    endtask

    task automatic test_misaligned;
        logic [7:0]  ops [4];
        logic [31:0] adr [4];
        logic [1:0]  flg [4];
        ops = '{LW, SW, LH, SH};
        adr = '{32'h101, 32'h102, 32'h103, 32'h11};
        flg = '{2'b10, 2'b01, 2'b10, 2'b01};
        for (int i = 0; i < 4; i++) begin
            obs_t o;
            do_access(ops[i], adr[i], 32'h0, 32'h0, 0);
            o = obs_q.pop_front();
            checks++;
            if ({o.lerr, o.serr} !== flg[i] || o.reqs !== 0 ||
                o.stalls !== 0 || o.en !== 1'b0)
                $display("FAIL misalign%0d got err=%b req=%0d stall=%0d en=%b",
                         i, {o.lerr, o.serr}, o.reqs, o.stalls, o.en);
            else passes++;
        end
        @(negedge clock);
        checks++;
        if (bus_request !== 1'b0)
            $display("FAIL misalign_req got %b want 0", bus_request);
        else passes++;
        @(posedge clock);
        #1;
    endtask

    task automatic test_timeout;
        obs_t o;
        do_access(LW, 32'h200, 32'h0, 32'h0, -1);
        o = obs_q.pop_front();
        checks++;
        if (o.reqs !== 16 || o.stalls !== 17 || o.cycles !== 18)
            $display("FAIL timeout_timing got req=%0d stall=%0d cyc=%0d",
                     o.reqs, o.stalls, o.cycles);
        else passes++;
        checks++;
        if (o.err !== 1'b1 || o.en !== 1'b0)
            $display("FAIL timeout_flag got err=%b en=%b want 1/0",
                     o.err, o.en);
        else passes++;
        @(negedge clock);
        checks++;
        if (bus_error !== 1'b0 || stall_request !== 1'b0)
            $display("FAIL timeout_after got err=%b stall=%b want 0/0",
                     bus_error, stall_request);
        else passes++;
        @(posedge clock);
        #1;
    endtask

    task automatic test_passthrough;
        obs_t o;
        exp_t e;
        exp_q.push_back('{d: 32'h5A5A1234, sel: 4'b0000, en: 1, stalls: 0});
        do_access(8'h21, 32'h101, 32'h0, 32'h0, 0);
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (o.d !== e.d || o.en !== e.en || o.wa !== 5'd9 ||
            o.stalls !== e.stalls || o.lerr !== 1'b0 || o.reqs !== 0)
            $display("FAIL passthru got d=%h en=%b wa=%0d stall=%0d",
                     o.d, o.en, o.wa, o.stalls);
        else passes++;
    endtask

    task automatic test_flush;
        obs_t o;
        aluop_input            = LW;
        memory_address_input   = 32'h300;
        bus_read_data          = 32'h1111_1111;
        write_reg_enable_input = 1'b1;
        @(negedge clock);
        @(posedge clock);
        #1;
        flush_input = 1'b1;
        @(negedge clock);
        checks++;
        if (stall_request !== 1'b0 || write_reg_enable_output !== 1'b0)
            $display("FAIL flush_comb got stall=%b en=%b want 0/0",
                     stall_request, write_reg_enable_output);
        else passes++;
        @(posedge clock);
        #1;
        flush_input            = 1'b0;
        aluop_input            = NOP;
        write_reg_enable_input = 1'b0;
        bus_ack                = 1'b1;
        @(negedge clock);
        checks++;
        if (bus_request !== 1'b0 || stall_request !== 1'b0)
            $display("FAIL flush_req got req=%b stall=%b want 0/0",
                     bus_request, stall_request);
        else passes++;
        @(posedge clock);
        #1;
        bus_ack = 1'b0;
        exp_q.push_back('{d: 32'h2222_2222, sel: 4'b1111, en: 1, stalls: 2});
        do_access(LW, 32'h304, 32'h0, 32'h2222_2222, 0);
        o = obs_q.pop_front();
        checks++;
        if (o.d !== exp_q[0].d || o.stalls !== exp_q[0].stalls ||
            o.cycles !== 3)
            $display("FAIL flush_next got d=%h stall=%0d cyc=%0d",
                     o.d, o.stalls, o.cycles);
        else passes++;
        void'(exp_q.pop_front());
    endtask

    task automatic test_back_to_back;
        time t0;
        exp_q.push_back('{d: 32'hA0A0_0001, sel: 4'b1111, en: 1, stalls: 2});
        exp_q.push_back('{d: 32'h0000_00B2, sel: 4'b0010, en: 1, stalls: 2});
        t0 = $time;
        do_access(LW, 32'h500, 32'h0, 32'hA0A0_0001, 0);
        do_access(LBU, 32'h502, 32'h0, 32'h0000_B200, 0);
        checks++;
        if ($time - t0 !== 60)
            $display("FAIL b2b_span got %0t want 60", $time - t0);
        else passes++;
        for (int i = 0; i < 2; i++) begin
            obs_t o;
            exp_t e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.d !== e.d || o.sel !== e.sel || o.stalls !== e.stalls ||
                o.cycles !== 3)
                $display("FAIL b2b%0d got d=%h sel=%b stall=%0d cyc=%0d",
                         i, o.d, o.sel, o.stalls, o.cycles);
            else passes++;
        end
    endtask

    task automatic test_reset_mid;
        aluop_input          = SW;
        memory_address_input = 32'h400;
        reg2_input           = 32'h1357_9BDF;
        @(negedge clock);
        @(posedge clock);
        #1;
        @(negedge clock);
        checks++;
        if (bus_request !== 1'b1 || bus_write_enable !== 1'b1)
            $display("FAIL rmid_busy got req=%b we=%b want 1/1",
                     bus_request, bus_write_enable);
        else passes++;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (stall_request !== 1'b0 || store_address_error !== 1'b0)
            $display("FAIL rmid_comb got stall=%b want 0", stall_request);
        else passes++;
        @(posedge clock);
        #1;
        @(negedge clock);
        checks++;
        if ({bus_request, bus_write_enable, bus_address, bus_select,
             bus_write_data} !== 70'h0)
            $display("FAIL rmid_regs got req=%b addr=%h sel=%b wd=%h want 0",
                     bus_request, bus_address, bus_select, bus_write_data);
        else passes++;
        @(posedge clock);
        #1;
        reset       = 1'b0;
        aluop_input = NOP;
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_lanes();
        test_store();
        test_misaligned();
        test_timeout();
        test_passthrough();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
